// File: rtl/clkgen_div.sv
// Programmable integer clock divider: clk_out has period cur_div clk cycles (high ceil(N/2), low floor(N/2)).
// Optional rising-edge counter output edge_cnt is enabled by defining CLKGEN_EDGE_CNT_EN.
module clkgen_div #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_DEF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
`ifdef CLKGEN_EDGE_CNT_EN
  ,
  output logic [31:0]      edge_cnt
`endif
);

  localparam logic [DIV_W-1:0] DIV_RST = (DIV_DEF < 2) ? DIV_W'(2) : DIV_W'(DIV_DEF);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             running_q, running_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             apply;
  logic [DIV_W:0]   div_p1;
  logic [DIV_W-1:0] hi_len, lo_len;

  // Widen before the +1 so the maximum ratio does not overflow.
  assign div_p1 = {1'b0, cur_div_q} + {{DIV_W{1'b0}}, 1'b1};
  assign hi_len = div_p1[DIV_W:1];
  assign lo_len = {1'b0, cur_div_q[DIV_W-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clk_out_d   = clk_out_q;
    rise_d      = 1'b0;
    running_d   = running_q;
    cfg_ready_d = cfg_ready_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cur_div_d   = cur_div_q;
    apply       = 1'b0;

    case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        running_d = 1'b0;
        cnt_d     = '0;
        apply     = pend_vld_q;
        if (en) begin
          state_d   = HIGH;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
          running_d = 1'b1;
          cnt_d     = DIV_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == hi_len) begin
          state_d   = LOW;
          clk_out_d = 1'b0;
          cnt_d     = DIV_W'(1);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == lo_len) begin
          apply = pend_vld_q;
          if (en) begin
            state_d   = HIGH;
            clk_out_d = 1'b1;
            rise_d    = 1'b1;
            cnt_d     = DIV_W'(1);
          end else begin
            state_d   = IDLE;
            running_d = 1'b0;
            cnt_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clk_out_d = 1'b0;
        running_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    if (apply) begin
      cur_div_d   = pend_q;
      pend_vld_d  = 1'b0;
      cfg_ready_d = 1'b1;
    end

    // Capture can never coincide with apply: apply needs pending set, which holds ready low.
    if (cfg_valid && cfg_ready_q) begin
      pend_d      = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
      pend_vld_d  = 1'b1;
      cfg_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_out_q   <= 1'b0;
      rise_q      <= 1'b0;
      running_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cur_div_q   <= DIV_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_out_q   <= clk_out_d;
      rise_q      <= rise_d;
      running_q   <= running_d;
      cfg_ready_q <= cfg_ready_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cur_div_q   <= cur_div_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign clk_out    = clk_out_q;
  assign rise_pulse = rise_q;
  assign running    = running_q;
  assign cur_div    = cur_div_q;

`ifdef CLKGEN_EDGE_CNT_EN
  logic [31:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (rise_d) edge_cnt_d = edge_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) edge_cnt_q <= '0;
    else     edge_cnt_q <= edge_cnt_d;
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule
